alu_pipe_unit: RTL and testbench

Registered, parametrised integer ALU for the R-type datapath.
- Implements the ten R-type operations with RISC-V-correct semantics:
  - sub = a-b (two's complement)
  - slt signed
  - sltu unsigned
  - shifts use the low log2(WIDTH) bits of operand b
- Uses a valid/ready handshake on both the input and output sides.
- Has an optional area-saving mode where shifts run one bit per cycle.
- Sits between the register-file read stage and the write-back stage.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_comb_core.sv | 46 ++++
 rtl/alu_pipe_unit.sv | 140 ++++++++++++++
 tb/tb_alu_pipe_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared op indices, FSM state type and shifter encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int NUM_OPS = 10;

  localparam int OP_ADD  = 9;
  localparam int OP_SUB  = 8;
  localparam int OP_OR   = 7;
  localparam int OP_XOR  = 6;
  localparam int OP_AND  = 5;
  localparam int OP_SLT  = 4;
  localparam int OP_SLTU = 3;
  localparam int OP_SLL  = 2;
  localparam int OP_SRL  = 1;
  localparam int OP_SRA  = 0;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_comb_core.sv
// ============================================================================
// Module   : alu_comb_core
// Purpose  : Combinational compute of the ten R-type ops plus one-hot check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [NUM_OPS-1:0] op_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic               op_err
);

  logic [SHW-1:0] shamt;
  logic           onehot;

  assign shamt  = b[SHW-1:0];
  assign onehot = (op_en != '0) && ((op_en & (op_en - NUM_OPS'(1))) == '0);
  assign op_err = !onehot;

  always_comb begin
    result = '0;
    if (onehot) begin
      if      (op_en[OP_ADD])  result = a + b;
      else if (op_en[OP_SUB])  result = a - b;
      else if (op_en[OP_OR])   result = a | b;
      else if (op_en[OP_XOR])  result = a ^ b;
      else if (op_en[OP_AND])  result = a & b;
      else if (op_en[OP_SLT])  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      else if (op_en[OP_SLTU]) result = {{(WIDTH-1){1'b0}}, (a < b)};
      else if (op_en[OP_SLL])  result = a << shamt;
      else if (op_en[OP_SRL])  result = a >> shamt;
      else                     result = $signed(a) >>> shamt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe_unit.sv
// ============================================================================
// Module   : alu_pipe_unit
// Purpose  : Registered ALU stage with valid/ready handshake and optional
//            bit-serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_ITER = 0,
  parameter int SHW        = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_OPS-1:0] op_en,
  input  logic [WIDTH-1:0]   read_data1,
  input  logic [WIDTH-1:0]   read_data2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               op_err
);

  logic [WIDTH-1:0] core_result;
  logic             core_err;

  state_e           state_q,     state_d;
  logic [SHW-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0] sh_val_q,    sh_val_d;
  logic [1:0]       sh_op_q,     sh_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q,   alu_out_d;
  logic             op_err_q,    op_err_d;

  logic             slot_free;
  logic             accept;
  logic             iter_start;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sh_next;

  alu_comb_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op_en  (op_en),
    .a      (read_data1),
    .b      (read_data2),
    .result (core_result),
    .op_err (core_err)
  );

  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = !rst && (state_q == ST_IDLE) && slot_free;
  assign accept     = in_valid && in_ready;
  assign shamt      = read_data2[SHW-1:0];
  assign iter_start = (SHIFT_ITER != 0) && !core_err && (shamt != '0)
                      && (op_en[OP_SLL] || op_en[OP_SRL] || op_en[OP_SRA]);

  always_comb begin
    case (sh_op_q)
      SH_SLL:  sh_next = {sh_val_q[WIDTH-2:0], 1'b0};
      SH_SRL:  sh_next = {1'b0, sh_val_q[WIDTH-1:1]};
      default: sh_next = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_val_d    = sh_val_q;
    sh_op_d     = sh_op_q;
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = alu_out_q;
    op_err_d    = op_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (iter_start) begin
            state_d  = ST_SHIFT;
            cnt_d    = shamt;
            sh_val_d = read_data1;
            sh_op_d  = op_en[OP_SLL] ? SH_SLL : (op_en[OP_SRL] ? SH_SRL : SH_SRA);
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = core_result;
            op_err_d    = core_err;
          end
        end
      end
      ST_SHIFT: begin
        // The final step doubles as the write; it waits if the old result is still held.
        if (cnt_q != SHW'(1)) begin
          sh_val_d = sh_next;
          cnt_d    = cnt_q - SHW'(1);
        end else if (slot_free) begin
          sh_val_d    = sh_next;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          alu_out_d   = sh_next;
          op_err_d    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_val_q    <= '0;
      sh_op_q     <= SH_SLL;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_val_q    <= sh_val_d;
      sh_op_q     <= sh_op_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      op_err_q    <= op_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign op_err    = op_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_unit.sv
// ============================================================================
// Module   : tb_alu_pipe_unit
// Purpose  : Scoreboard bench for a barrel-shift and an iterative-shift ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe_unit;
  import alu_pkg::*;

  localparam logic [9:0] C_ADD  = 10'b1000000000;
  localparam logic [9:0] C_SUB  = 10'b0100000000;
  localparam logic [9:0] C_OR   = 10'b0010000000;
  localparam logic [9:0] C_XOR  = 10'b0001000000;
  localparam logic [9:0] C_AND  = 10'b0000100000;
  localparam logic [9:0] C_SLT  = 10'b0000010000;
  localparam logic [9:0] C_SLTU = 10'b0000001000;
  localparam logic [9:0] C_SLL  = 10'b0000000100;
  localparam logic [9:0] C_SRL  = 10'b0000000010;
  localparam logic [9:0] C_SRA  = 10'b0000000001;

  typedef struct {
    logic [31:0] val;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv0 = 1'b0, or0 = 1'b1, ir0, ov0, err0;
  logic        iv1 = 1'b0, or1 = 1'b1, ir1, ov1, err1;
  logic [9:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, y0, y1;

  alu_pipe_unit #(.WIDTH(32), .SHIFT_ITER(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op_en(op0),
    .read_data1(a0), .read_data2(b0), .out_valid(ov0), .out_ready(or0),
    .alu_out(y0), .op_err(err0)
  );

  alu_pipe_unit #(.WIDTH(32), .SHIFT_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op_en(op1),
    .read_data1(a1), .read_data2(b1), .out_valid(ov1), .out_ready(or1),
    .alu_out(y1), .op_err(err1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0 unexpected result: got 0x%08h, expected no output", y0);
      end else begin
        e = q0.pop_front();
        chk("dut0 alu_out", y0, e.val);
        chk("dut0 op_err", {31'b0, err0}, {31'b0, e.err});
        if (e.cyc >= 0) chk("dut0 latency cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1 unexpected result: got 0x%08h, expected no output", y1);
      end else begin
        e = q1.pop_front();
        chk("dut1 alu_out", y1, e.val);
        chk("dut1 op_err", {31'b0, err1}, {31'b0, e.err});
        if (e.cyc >= 0) chk("dut1 latency cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // lat: expected cycles to result, -1 = don't check timing, -2 = don't score.
  task automatic issue(input bit sel, input logic [9:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input logic err, input int lat);
    exp_t e;
    int   waited = 0;
    bit   ok = 1'b0;
    if (sel) begin iv1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else     begin iv0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    while (!ok && waited < 100) begin
      @(negedge clk);
      if ((sel ? ir1 : ir0) === 1'b1) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      e.val = exp; e.err = err; e.cyc = (lat < 0) ? -1 : cyc + lat;
      if (lat != -2) begin
        if (sel) q1.push_back(e); else q0.push_back(e);
      end
    end else begin
      n_tests++; n_fail++;
      $display("FAIL dut%0d accept timeout: in_ready stayed 0, expected 1", sel);
    end
    @(posedge clk); #1;
    if (sel) iv1 = 1'b0; else iv0 = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready0", {31'b0, ir0}, 32'd0);
    chk("reset out_valid0", {31'b0, ov0}, 32'd0);
    chk("reset alu_out0", y0, 32'd0);
    chk("reset op_err0", {31'b0, err0}, 32'd0);
    chk("reset in_ready1", {31'b0, ir1}, 32'd0);
    chk("reset out_valid1", {31'b0, ov1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle unit: arithmetic, logic, signedness, shifts.
    issue(0, C_ADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 0, 1);
    issue(0, C_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 0, 1);
    issue(0, C_SLT,  32'h80000000, 32'h1,        32'h00000001, 0, 1);
    issue(0, C_SLTU, 32'h80000000, 32'h1,        32'h00000000, 0, 1);
    issue(0, C_SRA,  32'h80000000, 32'h24,       32'hF8000000, 0, 1);
    issue(0, C_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 0, 1);
    issue(0, C_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 0, 1);
    issue(0, C_AND,  32'h12345678, 32'h0F0F0F0F, 32'h02040608, 0, 1);
    issue(0, C_SLL,  32'h1,        32'h21,       32'h00000002, 0, 1);
    issue(0, C_SRL,  32'h80000000, 32'd31,       32'h00000001, 0, 1);
    issue(0, 10'b0000000000, 32'h5, 32'h3, 32'h0, 1, 1);
    issue(0, 10'b1100000000, 32'h5, 32'h3, 32'h0, 1, 1);

    // Back-to-back burst.
    issue(0, C_ADD, 32'd1,        32'd2,        32'd3,        0, 1);
    issue(0, C_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 0, 1);
    issue(0, C_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 0, 1);
    issue(0, C_SRL, 32'hF0000000, 32'd4,        32'h0F000000, 0, 1);
    repeat (2) @(posedge clk); #1;

    // Output hold under back-pressure.
    or0 = 1'b0;
    issue(0, C_ADD, 32'd10, 32'd20, 32'd30, 0, -1);
    iv0 = 1'b1; op0 = C_SUB; a0 = 32'd100; b0 = 32'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold in_ready", {31'b0, ir0}, 32'd0);
      chk("hold alu_out", y0, 32'd30);
      chk("hold out_valid", {31'b0, ov0}, 32'd1);
    end
    @(posedge clk); #1;
    or0 = 1'b1;
    issue(0, C_SUB, 32'd100, 32'd1, 32'd99, 0, 1);

    // Iterative unit.
    issue(1, C_SLL, 32'h1,        32'd31, 32'h80000000, 0, 32);
    issue(1, C_SRL, 32'h80,       32'd0,  32'h00000080, 0, 1);
    issue(1, C_SRA, 32'h80000000, 32'h24, 32'hF8000000, 0, 5);
    issue(1, C_ADD, 32'd7,        32'd8,  32'd15,       0, 1);
    issue(1, 10'b0000000110, 32'h1, 32'h4, 32'h0, 1, 1);
    repeat (8) @(posedge clk); #1;

    // Reset in the middle of a shift.
    issue(1, C_SLL, 32'h1, 32'd20, 32'h0, 0, -2);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-shift reset out_valid1", {31'b0, ov1}, 32'd0);
    chk("mid-shift reset alu_out1", y1, 32'd0);
    chk("mid-shift reset in_ready1", {31'b0, ir1}, 32'd1);
    repeat (25) @(posedge clk); #1;
    issue(1, C_ADD, 32'd3, 32'd4, 32'd7, 0, 1);

    for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    chk("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
    chk("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
